nes_joypad_ctrl: RTL and testbench

- Emulates the two NES standard-controller ports at CPU addresses $4016 and $4017 on the CPU clock.
- Converts the MicroBlaze USB keycode GPIO words into two 8-button states.
- Implements the strobe/latch/serial-shift protocol the CPU drives through the hardware decoder's controller chip select.
- Read data merges onto the CPU data bus alongside memory and PPU reads.

---
 rtl/nes_joypad_ctrl.sv | 106 ++++++++++
 tb/tb_nes_joypad_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_ctrl.sv
// NES standard-controller pair at $4016/$4017: USB keycodes are synchronized, decoded to
// button bits, then serialized through the strobe/shift protocol onto the CPU data bus.
module nes_joypad_ctrl #(
  parameter logic [63:0] P1_KEYMAP      = 64'h1A_16_04_07_28_2B_0E_0D,
  parameter logic [63:0] P2_KEYMAP      = 64'h52_51_50_4F_5C_5B_5A_59,
  parameter bit          BLOCK_OPPOSING = 1'b1,
  parameter logic [7:0]  OPEN_BUS       = 8'h40
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cs_n,
  input  logic        addr,
  input  logic        rw,
  input  logic        rdy,
  input  logic [7:0]  wr_data,
  input  logic [31:0] keycode0,
  input  logic [31:0] keycode1,
  output logic [7:0]  rd_data,
  output logic [7:0]  buttons_p1,
  output logic [7:0]  buttons_p2,
  output logic        strobe
);

  logic [63:0] key_meta;
  logic [63:0] key_sync;
  logic [7:0]  shift_p1;
  logic [7:0]  shift_p2;
  logic        acc;
  logic        rd;
  logic        wr;
  logic        unused_wr;

  assign acc       = ~cs_n & rdy;
  assign rd        = acc & rw;
  assign wr        = acc & ~rw;
  assign unused_wr = ^wr_data[7:1];

  // Bit i is set when any held key matches keymap byte i; a zero keymap byte never matches.
  function automatic logic [7:0] decode_keys(input logic [63:0] keys, input logic [63:0] map);
    logic [7:0] hit;
    hit = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (map[i*8 +: 8] != 8'h00 && keys[j*8 +: 8] == map[i*8 +: 8]) begin
          hit[i] = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  function automatic logic [7:0] filter_opposing(input logic [7:0] raw);
    logic [7:0] b;
    b = raw;
    if (BLOCK_OPPOSING) begin
      if (b[4] && b[5]) b[5:4] = 2'b00;
      if (b[6] && b[7]) b[7:6] = 2'b00;
    end
    return b;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_meta   <= '0;
      key_sync   <= '0;
      buttons_p1 <= '0;
      buttons_p2 <= '0;
    end else begin
      key_meta   <= {keycode1, keycode0};
      key_sync   <= key_meta;
      buttons_p1 <= filter_opposing(decode_keys(key_sync, P1_KEYMAP));
      buttons_p2 <= filter_opposing(decode_keys(key_sync, P2_KEYMAP));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      strobe <= 1'b0;
    end else if (wr && !addr) begin
      strobe <= wr_data[0];
    end
  end

  // While strobe is high the registers track the buttons; reads only shift once it drops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shift_p1 <= '0;
      shift_p2 <= '0;
    end else if (strobe) begin
      shift_p1 <= buttons_p1;
      shift_p2 <= buttons_p2;
    end else begin
      if (rd && !addr) shift_p1 <= {1'b1, shift_p1[7:1]};
      if (rd && addr)  shift_p2 <= {1'b1, shift_p2[7:1]};
    end
  end

  // Driven whenever selected for read, even while stalled, so a re-read sees the same bit.
  always_comb begin
    rd_data = 8'h00;
    if (!Reset && !cs_n && rw) begin
      rd_data = {OPEN_BUS[7:1], addr ? shift_p2[0] : shift_p1[0]};
    end
  end

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
// Directed bench for nes_joypad_ctrl: stimulus queues expected values, a negedge monitor checks.
module tb_nes_joypad_ctrl;

  // Key codes taken from the byte positions of the default keymaps.
  localparam logic [7:0] K_A      = 8'h0D;  // P1 byte 0
  localparam logic [7:0] K_B      = 8'h0E;  // P1 byte 1
  localparam logic [7:0] K_START  = 8'h28;  // P1 byte 3
  localparam logic [7:0] K_UP     = 8'h07;  // P1 byte 4
  localparam logic [7:0] K_DOWN   = 8'h04;  // P1 byte 5
  localparam logic [7:0] K_LEFT   = 8'h16;  // P1 byte 6
  localparam logic [7:0] K_RIGHT  = 8'h1A;  // P1 byte 7
  localparam logic [7:0] K2_RIGHT = 8'h52;  // P2 byte 7

  localparam int SelRd = 0, SelP1 = 1, SelP2 = 2, SelStb = 3, SelP1Nb = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cs_n, addr, rw, rdy;
  logic [7:0]  wr_data;
  logic [31:0] keycode0, keycode1;
  logic [7:0]  rd_data, buttons_p1, buttons_p2;
  logic        strobe;
  logic [7:0]  rd_data_nb, buttons_p1_nb, buttons_p2_nb;
  logic        strobe_nb;

  nes_joypad_ctrl u_dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .cs_n       (cs_n),
    .addr       (addr),
    .rw         (rw),
    .rdy        (rdy),
    .wr_data    (wr_data),
    .keycode0   (keycode0),
    .keycode1   (keycode1),
    .rd_data    (rd_data),
    .buttons_p1 (buttons_p1),
    .buttons_p2 (buttons_p2),
    .strobe     (strobe)
  );

  nes_joypad_ctrl #(.BLOCK_OPPOSING(1'b0)) u_dut_nb (
    .Clk        (Clk),
    .Reset      (Reset),
    .cs_n       (cs_n),
    .addr       (addr),
    .rw         (rw),
    .rdy        (rdy),
    .wr_data    (wr_data),
    .keycode0   (keycode0),
    .keycode1   (keycode1),
    .rd_data    (rd_data_nb),
    .buttons_p1 (buttons_p1_nb),
    .buttons_p2 (buttons_p2_nb),
    .strobe     (strobe_nb)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc_cnt = 0;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic push_exp(input int sel, input logic [7:0] val, input string name);
    exp_t e;
    e.cyc = cyc_cnt;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t       e;
    string      nm;
    logic [7:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e  = sb.pop_front();
      nm = sb_name.pop_front();
      case (e.sel)
        SelRd:   act = rd_data;
        SelP1:   act = buttons_p1;
        SelP2:   act = buttons_p2;
        SelStb:  act = {7'b0, strobe};
        SelP1Nb: act = buttons_p1_nb;
        default: act = 8'hxx;
      endcase
      checks++;
      if (e.cyc != cyc_cnt || act !== e.val) begin
        errors++;
        $display("FAIL %s: got %02h, want %02h (cycle %0d, queued %0d)",
                 nm, act, e.val, cyc_cnt, e.cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    cs_n = 1'b1; rw = 1'b1; addr = 1'b0; rdy = 1'b1; wr_data = 8'h00;
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    cs_n = 1'b0; rw = 1'b0; addr = a; rdy = 1'b1; wr_data = d;
    tick();
    idle();
  endtask

  task automatic cpu_read(input logic a, input logic [7:0] exp, input string name);
    cs_n = 1'b0; rw = 1'b1; addr = a; rdy = 1'b1;
    push_exp(SelRd, exp, name);
    tick();
    idle();
  endtask

  initial begin
    logic [9:0] seq;
    idle();
    keycode0 = '0;
    keycode1 = '0;
    Reset = 1'b1;
    tick(2);

    // Reset state, including a read attempted while reset is held
    cs_n = 1'b0; rw = 1'b1;
    push_exp(SelRd, 8'h00, "rst_rd_data");
    push_exp(SelStb, 8'h00, "rst_strobe");
    push_exp(SelP1, 8'h00, "rst_p1");
    push_exp(SelP2, 8'h00, "rst_p2");
    tick();
    idle();
    Reset = 1'b0;
    push_exp(SelRd, 8'h00, "deselected_rd");
    tick();

    // J pressed: exactly 3 edges of latency, then a no-strobe read sees a zero shift register
    keycode0 = {24'h0, K_A};
    tick(2);
    push_exp(SelP1, 8'h00, "latency_2_edges");
    tick();
    push_exp(SelP1, 8'h01, "latency_3_edges");
    push_exp(SelP2, 8'h00, "p2_unaffected");
    cpu_read(1'b0, 8'h40, "no_strobe_read");

    // Up+J, strobe pulse, ten serial reads
    keycode0 = {16'h0, K_UP, K_A};
    tick(3);
    cpu_write(1'b0, 8'h01);
    push_exp(SelStb, 8'h01, "strobe_set");
    cpu_write(1'b0, 8'h00);
    push_exp(SelStb, 8'h00, "strobe_clear");
    seq = 10'b11_0001_0001;
    for (int k = 0; k < 10; k++) begin
      cpu_read(1'b0, 8'h40 | {7'b0, seq[k]}, $sformatf("serial_read_%0d", k + 1));
    end

    // Strobe held: reads return the live A bit and never advance
    keycode0 = {24'h0, K_A};
    tick(3);
    cpu_write(1'b0, 8'h01);
    tick();
    for (int k = 0; k < 3; k++) cpu_read(1'b0, 8'h41, $sformatf("strobe_held_rd_%0d", k));
    keycode0 = '0;
    for (int k = 0; k < 6; k++) begin
      cpu_read(1'b0, (k < 4) ? 8'h41 : 8'h40, $sformatf("strobe_release_rd_%0d", k));
    end
    push_exp(SelStb, 8'h01, "strobe_still_set");
    cpu_write(1'b0, 8'h00);

    // Opposing-direction filter, blocked and unblocked instances side by side
    keycode0 = {16'h0, K_DOWN, K_UP};
    tick(3);
    push_exp(SelP1, 8'h00, "block_up_down");
    push_exp(SelP1Nb, 8'h30, "noblock_up_down");
    keycode0 = {8'h0, K_LEFT, K_RIGHT, K_A};
    tick(3);
    push_exp(SelP1, 8'h01, "block_left_right");
    push_exp(SelP1Nb, 8'hC1, "noblock_left_right");
    keycode0 = {16'h0, K_LEFT, K_UP};
    tick(3);
    push_exp(SelP1, 8'h50, "left_up_not_blocked");
    tick();

    // Player 2 Right; $4017 write ignored; $4016 shifting independent of $4017
    keycode0 = '0;
    keycode1 = {16'h0, K2_RIGHT, 8'h00};
    tick(3);
    push_exp(SelP2, 8'h80, "p2_right");
    push_exp(SelP1, 8'h00, "p1_empty");
    cpu_write(1'b1, 8'h01);
    push_exp(SelStb, 8'h00, "write_4017_ignored");
    cpu_write(1'b0, 8'h01);
    cpu_write(1'b0, 8'h00);
    cpu_read(1'b0, 8'h40, "p1_read_1");
    for (int k = 0; k < 9; k++) begin
      cpu_read(1'b1, (k >= 7) ? 8'h41 : 8'h40, $sformatf("p2_read_%0d", k + 1));
    end
    cpu_read(1'b0, 8'h40, "p1_read_2");

    // B+Start = 0x0A: stall on read 2, exactly one shift, then async reset
    keycode1 = '0;
    keycode0 = {16'h0, K_START, K_B};
    tick(3);
    push_exp(SelP1, 8'h0A, "p1_b_start");
    cpu_write(1'b0, 8'h01);
    cpu_write(1'b0, 8'h00);
    cpu_read(1'b0, 8'h40, "stall_read_1");
    cs_n = 1'b0; rw = 1'b1; addr = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_exp(SelRd, 8'h41, $sformatf("stalled_read_2_%0d", k));
      tick();
    end
    rdy = 1'b1;
    push_exp(SelRd, 8'h41, "released_read_2");
    tick();
    idle();
    cpu_read(1'b0, 8'h40, "stall_read_3");
    cpu_write(1'b0, 8'h01);
    push_exp(SelStb, 8'h01, "pre_reset_strobe");
    tick();
    Reset = 1'b1;
    cs_n = 1'b0; rw = 1'b1;
    push_exp(SelStb, 8'h00, "async_rst_strobe");
    push_exp(SelP1, 8'h00, "async_rst_p1");
    push_exp(SelRd, 8'h00, "async_rst_rd_data");
    tick();
    idle();
    Reset = 1'b0;
    cpu_read(1'b0, 8'h40, "post_reset_read");

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
